// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM states, redirect kinds and default reset PC for the instruction fetch unit
package ifu_pkg;
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_FAULT} ifu_state_e;
  localparam logic [1:0] RK_BRANCH = 2'd0;
  localparam logic [1:0] RK_JUMP = 2'd1;
  localparam logic [1:0] RK_JR = 2'd2;
  localparam logic [1:0] RK_NONE = 2'd3;
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/ifu_target_calc.sv
// ifu_target_calc: combinational redirect target for branch, jump and jr
module ifu_target_calc
  import ifu_pkg::*;
(
  input  logic [1:0]  i_kind,
  input  logic [31:0] i_base,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_tgt26,
  input  logic [31:0] i_reg,
  output logic [31:0] o_target
);
  logic [31:0] w_branch;
  logic [31:0] w_jump;
  assign w_branch = i_base + {{14{i_imm16[15]}}, i_imm16, 2'b00};
  assign w_jump = {i_base[31:28], i_tgt26, 2'b00};
  // the reserved kind yields the base; the caller never acts on it
  always_comb
    o_target = (i_kind == RK_BRANCH) ? w_branch :
               (i_kind == RK_JUMP)   ? w_jump   :
               (i_kind == RK_JR)     ? i_reg    : i_base;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner, imem req/ack fetcher and redirect handler; IFU_ALIGN_CHECK_EN adds align_fault
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
`ifdef IFU_ALIGN_CHECK_EN
  output logic              align_fault,
`endif
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       pc_out,
  output logic [31:0]       pc_plus4,
  input  logic              redirect_valid,
  input  logic [1:0]        redirect_kind,
  input  logic [31:0]       redirect_base,
  input  logic [15:0]       redirect_imm16,
  input  logic [25:0]       redirect_tgt26,
  input  logic [31:0]       redirect_reg
);
  ifu_state_e  r_state;
  ifu_state_e  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic [31:0] w_target;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_nxt;
  logic        r_req;
  logic        r_valid;
  logic        r_squash;
  logic        w_ack;
  logic        w_redir;
  logic        w_fault;
  logic        w_take;
  logic        w_accept;
  logic        w_new_req;

  ifu_target_calc u_target (
    .i_kind   (redirect_kind),
    .i_base   (redirect_base),
    .i_imm16  (redirect_imm16),
    .i_tgt26  (redirect_tgt26),
    .i_reg    (redirect_reg),
    .o_target (w_target)
  );

  assign w_ack = imem_ack & r_req;
  assign w_redir = redirect_valid & (redirect_kind != RK_NONE) & (r_state != S_FAULT);
`ifdef IFU_ALIGN_CHECK_EN
  assign w_tgt = w_target;
  assign w_fault = w_redir & (|w_target[1:0]);
`else
  assign w_tgt = w_target & ~32'd3;
  assign w_fault = 1'b0;
`endif
  // a returned word is kept only if nothing squashed it or redirects this cycle
  assign w_take = w_ack & ~r_squash & ~w_redir;
  assign w_accept = (r_state == S_HOLD) & r_valid & instr_ready;
  // a fresh address is latched only when no request is left outstanding
  assign w_new_req = (w_state_nxt == S_FETCH) & (~r_req | w_ack);

  // next state and next PC
  always_comb begin
    w_state_nxt = w_fault ? S_FAULT :
                  w_take  ? S_HOLD  :
                  ((r_state == S_HOLD) && (w_redir || w_accept)) ? S_FETCH : r_state;
    w_pc_nxt = w_fault ? r_pc : w_redir ? w_tgt : w_take ? r_pc + 32'd4 : r_pc;
  end

  // fetch FSM, PC, request address and the held instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_addr   <= RESET_PC;
      r_req    <= 1'b0;
      r_squash <= 1'b0;
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_pc_out <= RESET_PC;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req    <= w_state_nxt == S_FETCH;
      r_squash <= (r_state == S_FETCH) & ~w_fault & ~w_ack & (r_squash | (w_redir & r_req));
      r_valid  <= w_state_nxt == S_HOLD;
      if (w_new_req) r_addr <= w_pc_nxt;
      if (w_take) begin
        r_instr  <= imem_rdata;
        r_pc_out <= r_pc;
      end
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  logic r_align_fault;
  // sticky misaligned-target flag
  always_ff @(posedge clk) begin
    if (reset) r_align_fault <= 1'b0;
    else if (w_fault) r_align_fault <= 1'b1;
  end
  assign align_fault = r_align_fault;
`endif

  assign imem_req = r_req;
  assign imem_addr = r_addr[ADDR_W-1:0];
  assign instr_out = r_instr;
  assign instr_valid = r_valid;
  assign pc_out = r_pc_out;
  assign pc_plus4 = r_pc_out + 32'd4;
endmodule
